// File: rtl/rgb_fifo_pkg.sv
// Shared types and sizing for the RGB FIFO write-side controller.
package rgb_fifo_pkg;
   localparam int FIFO_DEPTH = 64;
   localparam int PTR_W      = 6;
   localparam int LVL_W      = 7;

   typedef logic [2:0] rgb_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;
endpackage

// File: rtl/rgb_fifo_write_arbiter_level.sv
// Occupancy tracker for the RGB FIFO: counts own writes against scan-out reads,
// flags almost-empty and latches a sticky underflow on reads from an empty FIFO.
module fifo_level_counter #(
   parameter int DEPTH  = 64,
   parameter int LOW_WM = 16,
   parameter int LW     = $clog2(DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic          rd,
   output logic [LW-1:0] level,
   output logic          almost_empty,
   output logic          underflow_err
);
   logic [LW-1:0] level_q, level_d;
   logic          underflow_q;
   logic          rd_eff;

   // a read of an empty FIFO does not count, it only raises the sticky flag
   assign rd_eff  = rd && (level_q != '0);
   assign level_d = level_q + LW'(we) - LW'(rd_eff);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         level_q <= level_d;
         if (rd && (level_q == '0))
            underflow_q <= 1'b1;
      end
   end

   assign level         = level_q;
   assign almost_empty  = (level_q <= LW'(LOW_WM));
   assign underflow_err = underflow_q;
endmodule

// File: rtl/rgb_fifo_write_arbiter.sv
// Round-robin burst arbiter for the shared RGB FIFO write port.
// Define RGB_ARB_FIXED_PRIO_EN to make requester 0 always win IDLE ties.
module rgb_fifo_write_arbiter
   import rgb_fifo_pkg::*;
#(
   parameter int DATA_W = 3,
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int BURST  = 8,
   parameter int LOW_WM = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req0,
   input  logic [DATA_W-1:0]        data0,
   output logic                     ack0,
   input  logic                     req1,
   input  logic [DATA_W-1:0]        data1,
   output logic                     ack1,
   input  logic                     fifo_rd,
   output logic                     fifo_we,
   output logic [DATA_W-1:0]        fifo_din,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     almost_empty,
   output logic                     underflow_err
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(BURST) + 1;

   arb_state_t    state_q;
   logic          last_gnt_q;
   logic [CW-1:0] burst_cnt_q;
   logic          space;
   logic          req_cur;
   logic          tie_pick1;

   // space is judged on the registered level only, so a full FIFO being read
   // this cycle still blocks the write until the level register drops
   assign space   = (level < LW'(DEPTH));
   assign req_cur = (state_q == GNT1) ? req1 : req0;

`ifdef RGB_ARB_FIXED_PRIO_EN
   assign tie_pick1 = 1'b0;
`else
   assign tie_pick1 = ~last_gnt_q;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_gnt_q  <= 1'b1;
         burst_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 && req1)
                  state_q <= tie_pick1 ? GNT1 : GNT0;
               else if (req0)
                  state_q <= GNT0;
               else if (req1)
                  state_q <= GNT1;
            end
            GNT0, GNT1: begin
               if (!req_cur) begin
                  state_q     <= IDLE;
                  last_gnt_q  <= (state_q == GNT1);
                  burst_cnt_q <= '0;
               end else if (space) begin
                  if (burst_cnt_q == CW'(BURST - 1)) begin
                     state_q     <= IDLE;
                     last_gnt_q  <= (state_q == GNT1);
                     burst_cnt_q <= '0;
                  end else begin
                     burst_cnt_q <= burst_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      fifo_we  = 1'b0;
      ack0     = 1'b0;
      ack1     = 1'b0;
      fifo_din = '0;
      if (state_q == GNT0 && req0 && space) begin
         fifo_we  = 1'b1;
         ack0     = 1'b1;
         fifo_din = data0;
      end else if (state_q == GNT1 && req1 && space) begin
         fifo_we  = 1'b1;
         ack1     = 1'b1;
         fifo_din = data1;
      end
   end

   fifo_level_counter #(
      .DEPTH  (DEPTH),
      .LOW_WM (LOW_WM),
      .LW     (LW)
   ) u_level (
      .clock         (clock),
      .reset         (reset),
      .we            (fifo_we),
      .rd            (fifo_rd),
      .level         (level),
      .almost_empty  (almost_empty),
      .underflow_err (underflow_err)
   );
endmodule

// File: tb/tb_rgb_fifo_write_arbiter.sv
// Self-checking bench for rgb_fifo_write_arbiter: vector table plus directed
// corner sequences, with a per-requester scoreboard of presented words.
module tb_rgb_fifo_write_arbiter;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0, fifo_rd = 1'b0;
   logic [2:0] data0 = 3'd0, data1 = 3'd0;
   logic       ack0, ack1, fifo_we, almost_empty, underflow_err;
   logic [2:0] fifo_din;
   logic [6:0] level;

   int checks = 0;
   int errors = 0;
   int lvl_m  = 0;
   logic uf_m = 1'b0;
   logic [2:0] q0[$];
   logic [2:0] q1[$];

   typedef struct {
      logic r0, r1, rd;
      logic we, a0, a1;
      int   lvl;
   } vec_t;
   vec_t tv[14];

   rgb_fifo_write_arbiter dut (
      .clock(clock), .reset(reset),
      .req0(req0), .data0(data0), .ack0(ack0),
      .req1(req1), .data1(data1), .ack1(ack1),
      .fifo_rd(fifo_rd), .fifo_we(fifo_we), .fifo_din(fifo_din),
      .level(level), .almost_empty(almost_empty), .underflow_err(underflow_err)
   );

   always #5 clock = ~clock;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Entered at posedge+1: drive inputs, settle, check invariants and scoreboard.
   task automatic drive(input logic r0, input logic r1, input logic rd);
      req0 = r0; req1 = r1; fifo_rd = rd;
      if (r0 && q0.size() == 0) q0.push_back(data0);
      if (r1 && q1.size() == 0) q1.push_back(data1);
      #2;
      chk("ack_excl", 32'(ack0 & ack1), 0);
      chk("we_vs_ack", 32'(fifo_we), 32'(ack0 | ack1));
      if (!fifo_we) chk("din_idle", 32'(fifo_din), 0);
      chk("level_model", 32'(level), lvl_m);
      chk("ae_model", 32'(almost_empty), 32'(lvl_m <= 16));
      chk("uf_model", 32'(underflow_err), 32'(uf_m));
      if (ack0) begin
         if (q0.size() == 0) chk("ack0_no_word", 1, 0);
         else chk("din_src0", 32'(fifo_din), 32'(q0.pop_front()));
      end
      if (ack1) begin
         if (q1.size() == 0) chk("ack1_no_word", 1, 0);
         else chk("din_src1", 32'(fifo_din), 32'(q1.pop_front()));
      end
   endtask

   // Clock edge, then update the level model and advance acked requesters.
   task automatic adv();
      logic we_s, rd_s, a0_s, a1_s;
      we_s = fifo_we; rd_s = fifo_rd; a0_s = ack0; a1_s = ack1;
      @(posedge clock); #1;
      if (rd_s && lvl_m == 0) uf_m = 1'b1;
      lvl_m = lvl_m + int'(we_s) - ((rd_s && lvl_m != 0) ? 1 : 0);
      if (a0_s) data0 = 3'($urandom);
      if (a1_s) data1 = 3'($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; fifo_rd = 1'b0;
      #1;
      chk("rst_we", 32'(fifo_we), 0);
      chk("rst_ack0", 32'(ack0), 0);
      chk("rst_ack1", 32'(ack1), 0);
      chk("rst_din", 32'(fifo_din), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_uf", 32'(underflow_err), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      q0.delete(); q1.delete();
      lvl_m = 0; uf_m = 1'b0;
   endtask

   initial begin
      int src;
      logic exp_we;
      bit hit;

      // single requester, 10 words, no reads
      tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      for (int k = 1; k <= 8; k++) tv[k] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, k - 1};
      tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8};
      tv[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8};
      tv[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9};
      tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10};
      tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10};

      data0 = 3'($urandom); data1 = 3'($urandom);
      @(posedge clock); #1;
      do_reset();

      for (int i = 0; i < 14; i++) begin
         drive(tv[i].r0, tv[i].r1, tv[i].rd);
         chk($sformatf("tv%0d_we", i), 32'(fifo_we), 32'(tv[i].we));
         chk($sformatf("tv%0d_ack0", i), 32'(ack0), 32'(tv[i].a0));
         chk($sformatf("tv%0d_ack1", i), 32'(ack1), 32'(tv[i].a1));
         chk($sformatf("tv%0d_level", i), 32'(level), tv[i].lvl);
         adv();
      end

      // both requesting: 8-word bursts separated by one IDLE cycle
      do_reset();
      for (int k = 0; k < 36; k++) begin
         drive(1'b1, 1'b1, 1'b0);
`ifdef RGB_ARB_FIXED_PRIO_EN
         src = 0;
`else
         src = (k / 9) % 2;
`endif
         exp_we = (k % 9) != 0;
         chk($sformatf("rr%0d_ack0", k), 32'(ack0), 32'(exp_we && src == 0));
         chk($sformatf("rr%0d_ack1", k), 32'(ack1), 32'(exp_we && src == 1));
         adv();
      end
      drive(1'b0, 1'b0, 1'b0);
      chk("rr_level", 32'(level), 32);
      adv();

      // reset mid-burst, observed before any clock edge
      do_reset();
      for (int k = 0; k < 4; k++) begin drive(1'b1, 1'b0, 1'b0); adv(); end
      drive(1'b1, 1'b0, 1'b0);
      chk("mid_we_pre", 32'(fifo_we), 1);
      chk("mid_level_pre", 32'(level), 3);
      reset = 1'b1;
      #1;
      chk("mid_we", 32'(fifo_we), 0);
      chk("mid_ack0", 32'(ack0), 0);
      chk("mid_level", 32'(level), 0);
      chk("mid_ae", 32'(almost_empty), 1);
      do_reset();

      // fill to full, stall, then one read frees exactly one slot
      hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (level == 7'd64) begin hit = 1'b1; break; end
         drive(1'b1, 1'b0, 1'b0);
         adv();
      end
      chk("full_reached", 32'(hit), 1);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 1'b0);
         chk("full_we", 32'(fifo_we), 0);
         chk("full_ack0", 32'(ack0), 0);
         chk("full_level", 32'(level), 64);
         adv();
      end
      drive(1'b1, 1'b0, 1'b1);
      chk("full_rd_we", 32'(fifo_we), 0);
      adv();
      drive(1'b1, 1'b0, 1'b0);
      chk("refill_level", 32'(level), 63);
      chk("refill_we", 32'(fifo_we), 1);
      chk("refill_ack0", 32'(ack0), 1);
      adv();
      drive(1'b1, 1'b0, 1'b0);
      chk("refull_level", 32'(level), 64);
      chk("refull_we", 32'(fifo_we), 0);
      adv();

      // simultaneous read/write at 20, then drain to the watermark
      do_reset();
      hit = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (level == 7'd20) begin hit = 1'b1; break; end
         drive(1'b1, 1'b0, 1'b0);
         adv();
      end
      chk("lvl20_reached", 32'(hit), 1);
      drive(1'b0, 1'b0, 1'b0); adv();
      drive(1'b1, 1'b0, 1'b0); adv();
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b0, 1'b1);
         chk("rw_we", 32'(fifo_we), 1);
         chk("rw_level", 32'(level), 20);
         chk("rw_ae", 32'(almost_empty), 0);
         adv();
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         chk("drain_level", 32'(level), 20 - k);
         chk("drain_ae", 32'(almost_empty), 0);
         adv();
      end
      drive(1'b0, 1'b0, 1'b0);
      chk("wm_level", 32'(level), 16);
      chk("wm_ae", 32'(almost_empty), 1);
      adv();

      // underflow is sticky until reset
      do_reset();
      drive(1'b0, 1'b0, 1'b1);
      chk("uf_before", 32'(underflow_err), 0);
      adv();
      drive(1'b0, 1'b0, 1'b0);
      chk("uf_set", 32'(underflow_err), 1);
      chk("uf_level", 32'(level), 0);
      adv();
      for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b0, 1'b0); adv(); end
      drive(1'b0, 1'b0, 1'b0);
      chk("uf_sticky", 32'(underflow_err), 1);
      chk("uf_level2", 32'(level), 2);
      adv();
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
